// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// memory write-mode encodings, FSM state encoding and small decode helpers.
package lsu_pkg;

    // RV32I load/store funct3 codes (stores use only the first three)
    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU
    localparam logic [2:0] F3_HU = 3'b101;  // LHU

    // mem_write_mode encodings
    localparam logic [1:0] WM_NONE = 2'd0;
    localparam logic [1:0] WM_BYTE = 2'd1;
    localparam logic [1:0] WM_HALF = 2'd2;
    localparam logic [1:0] WM_WORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Access size in bytes; funct3[1:0]==3 is never legal, so its value is moot.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        unique case (funct3[1:0])
            2'd0:    access_size = 3'd1;
            2'd1:    access_size = 3'd2;
            default: access_size = 3'd4;
        endcase
    endfunction

    function automatic logic [1:0] write_mode_of(input logic [2:0] funct3);
        unique case (funct3)
            F3_B:    write_mode_of = WM_BYTE;
            F3_H:    write_mode_of = WM_HALF;
            F3_W:    write_mode_of = WM_WORD;
            default: write_mode_of = WM_NONE;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end else begin
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                           (funct3 == F3_BU) || (funct3 == F3_HU);
        end
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// slave  : the load/store unit itself (accepts requests, drives memory bus).
// master : the requester plus data memory (drives requests and mem_rdata).
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic [1:0]  mem_write_mode;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_read, mem_write_mode
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_wdata, mem_read, mem_write_mode
    );
endinterface

// File: rtl/load_align_ext.sv
// Load data extraction and extension. The addressed byte sits in
// mem_rdata[31:24]; halfwords use [31:16], words the full bus.
// Ports: funct3 (load width/sign code), mem_rdata (raw read data),
//        result (extended load value, 0 for unknown codes).
module load_align_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] mem_rdata,
    output logic [31:0] result
);
    always_comb begin
        result = '0;
        unique case (funct3)
            F3_B:    result = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
            F3_H:    result = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
            F3_W:    result = mem_rdata;
            F3_BU:   result = {24'b0, mem_rdata[31:24]};
            F3_HU:   result = {16'b0, mem_rdata[31:16]};
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit. Accepts one request in IDLE, performs
// one memory access in ACCESS (memory acts on the falling edge), reports in
// RESP for one cycle. Illegal requests skip ACCESS and report an error.
// Ports: clk, reset_n (async active-low), bus (load_store_unit_if.slave:
//        request handshake, response, data-memory bus).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES   = 16,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    load_store_unit_if.slave   bus
);
    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        is_store_q, is_store_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [2:0]  size;
    logic [32:0] last_byte;
    logic        range_err, align_err, req_err;
    logic [31:0] load_data;

    // Request legality, evaluated on the incoming request
    always_comb begin
        size      = access_size(bus.req_funct3);
        // 33-bit sum so an address near 2^32 cannot wrap into range
        last_byte = {1'b0, bus.req_addr} + {30'b0, size} - 33'd1;
        range_err = last_byte >= 33'(MEM_BYTES);
        align_err = CHECK_ALIGN &&
                    (((size == 3'd2) && bus.req_addr[0]) ||
                     ((size == 3'd4) && (bus.req_addr[1:0] != 2'b00)));
        req_err   = !funct3_legal(bus.req_is_store, bus.req_funct3) || range_err || align_err;
    end

    load_align_ext u_align (
        .funct3    (f3_q),
        .mem_rdata (bus.mem_rdata),
        .result    (load_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        is_store_d = is_store_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    rdata_d = '0;
                    if (req_err) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d      = 1'b0;
                        addr_d     = bus.req_addr;
                        wdata_d    = bus.req_wdata;
                        f3_d       = bus.req_funct3;
                        is_store_d = bus.req_is_store;
                        state_d    = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!is_store_q) rdata_d = load_data;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            is_store_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            is_store_q <= is_store_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    // Strobes decode straight from state so reset removes them at once
    always_comb begin
        bus.req_ready      = (state_q == IDLE);
        bus.resp_valid     = (state_q == RESP);
        bus.resp_rdata     = rdata_q;
        bus.resp_err       = err_q;
        bus.mem_addr       = addr_q;
        bus.mem_wdata      = wdata_q;
        bus.mem_read       = (state_q == ACCESS) && !is_store_q;
        bus.mem_write_mode = ((state_q == ACCESS) && is_store_q) ? write_mode_of(f3_q) : WM_NONE;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte-array memory on the falling edge,
// byte-level reference model, scoreboard queue checked by a response monitor.
module tb_load_store_unit;
    localparam int MEMB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_BYTES(MEMB), .CHECK_ALIGN(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mem[MEMB];
    logic [7:0]  ref_mem[MEMB];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          strobes = 0;
    int          exp_strobes = 0;
    int          resp_cnt = 0;
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Reference: requests complete in order, so the byte array can be updated at issue time
    task automatic model(input bit st, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, output logic err, output logic [31:0] rd);
        int  sz;
        bit  legal;
        bit [31:0] v;
        sz    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || (longint'(a) + sz > MEMB) ||
                (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
        rd = '0;
        if (!err) begin
            if (st) begin
                for (int i = 0; i < sz; i++) ref_mem[int'(a) + i] = wd[8*(sz-1-i) +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v = (v << 8) | 32'(ref_mem[int'(a) + i]);
                if (f3[2] || sz == 4) rd = v;
                else if (sz == 1) rd = {{24{v[7]}}, v[7:0]};
                else rd = {{16{v[15]}}, v[15:0]};
            end
        end
    endtask

    task automatic push_exp(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd);
        exp_t e;
        model(st, f3, a, wd, e.err, e.rd);
        // cyc is the count before the accepting edge
        e.due = cyc + (e.err ? 1 : 2);
        sb.push_back(e);
        if (!e.err) exp_strobes++;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) check("ready_timeout", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic issue(input bit st, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] wd, input bit track);
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        if (track) push_exp(st, f3, a, wd);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Data memory: acts on the falling edge, byte at mem_addr lands in rdata[31:24]
    initial forever begin
        int n;
        int a;
        @(negedge clk);
        a = int'(bus.mem_addr);
        if (bus.mem_read) begin
            strobes++;
            for (int i = 0; i < 4; i++)
                bus.mem_rdata[31-8*i -: 8] = (a + i < MEMB) ? mem[a + i] : 8'h00;
        end
        if (bus.mem_write_mode != 2'd0) begin
            strobes++;
            n = (bus.mem_write_mode == 2'd1) ? 1 : (bus.mem_write_mode == 2'd2) ? 2 : 4;
            for (int i = 0; i < n; i++)
                if (a + i < MEMB) mem[a + i] = bus.mem_wdata[8*(n-1-i) +: 8];
        end
    end

    // Response monitor
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            check("resp_valid_in_reset", 32'(bus.resp_valid), 32'd0);
        end else if (bus.resp_valid) begin
            resp_cnt++;
            last_rd  = bus.resp_rdata;
            last_err = bus.resp_err;
            if (sb.size() == 0) begin
                check("unexpected_resp", 32'(bus.resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rd);
                check("resp_err", 32'(bus.resp_err), 32'(e.err));
                check("resp_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
        check({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_mem_read"}, 32'(bus.mem_read), 32'd0);
        check({tag, "_mem_wm"}, 32'(bus.mem_write_mode), 32'd0);
    endtask

    initial begin
        bit          st;
        bit [2:0]    f3;
        bit [31:0]   a;
        int          rc;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        for (int i = 0; i < MEMB; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        #2 check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Word store then load
        issue(1'b1, 3'b010, 32'd4, 32'h11223344, 1'b1);
        issue(1'b0, 3'b010, 32'd4, 32'h0, 1'b1);
        drain();
        check("sw4_byte4", 32'(mem[4]), 32'h11);
        check("sw4_byte5", 32'(mem[5]), 32'h22);
        check("sw4_byte6", 32'(mem[6]), 32'h33);
        check("sw4_byte7", 32'(mem[7]), 32'h44);
        check("lw4_rdata", last_rd, 32'h11223344);

        // Byte/half stores and extended loads
        issue(1'b1, 3'b000, 32'd8, 32'h000000F0, 1'b1);
        issue(1'b0, 3'b000, 32'd8, 32'h0, 1'b1);
        drain();
        check("lb8", last_rd, 32'hFFFFFFF0);
        issue(1'b0, 3'b100, 32'd8, 32'h0, 1'b1);
        drain();
        check("lbu8", last_rd, 32'h000000F0);
        issue(1'b1, 3'b001, 32'd10, 32'h00008001, 1'b1);
        issue(1'b0, 3'b001, 32'd10, 32'h0, 1'b1);
        drain();
        check("lh10", last_rd, 32'hFFFF8001);
        issue(1'b0, 3'b101, 32'd10, 32'h0, 1'b1);
        drain();
        check("lhu10", last_rd, 32'h00008001);

        // Misalignment and range errors: no memory strobes
        issue(1'b0, 3'b001, 32'd5, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'd6, 32'h0, 1'b1);
        drain();
        check("misalign_err", 32'(last_err), 32'd1);
        issue(1'b0, 3'b010, 32'd12, 32'h0, 1'b1);
        drain();
        check("lw12_err", 32'(last_err), 32'd0);
        issue(1'b0, 3'b010, 32'd14, 32'h0, 1'b1);
        issue(1'b0, 3'b000, 32'd16, 32'h0, 1'b1);
        issue(1'b1, 3'b010, 32'hFFFFFFFC, 32'h5, 1'b1);
        drain();
        check("range_err", 32'(last_err), 32'd1);
        check("err_strobes", 32'(strobes), 32'(exp_strobes));

        // req_valid held through ACCESS and RESP: only one accept
        rc = resp_cnt;
        wait_ready();
        bus.req_valid    = 1'b1;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'b010;
        bus.req_addr     = 32'd4;
        push_exp(1'b0, 3'b010, 32'd4, 32'h0);
        @(posedge clk); #1 check("ready_in_access", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1 check("ready_in_resp", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1 bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        drain();
        check("held_valid_resps", 32'(resp_cnt - rc), 32'd1);

        // Reset during ACCESS aborts the store
        rc = resp_cnt;
        issue(1'b1, 3'b010, 32'd0, 32'hAABBCCDD, 1'b0);
        reset_n = 1'b0;
        #1 check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) check("abort_mem", 32'(mem[i]), 32'(ref_mem[i]));
        reset_n = 1'b1;
        check("abort_no_resp", 32'(resp_cnt - rc), 32'd0);
        issue(1'b0, 3'b010, 32'd0, 32'h0, 1'b1);
        drain();
        check("post_abort_lw", last_rd, {ref_mem[0], ref_mem[1], ref_mem[2], ref_mem[3]});

        // Randomized traffic
        for (int k = 0; k < 120; k++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, MEMB + 3));
            if ($urandom_range(0, 3) != 0) begin
                if (st) f3 = 3'($urandom_range(0, 2));
                else f3 = (f3 inside {3'd3, 3'd6, 3'd7}) ? 3'd2 : f3;
                if (f3[1:0] == 2'd1) a[0] = 1'b0;
                if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
            end
            issue(st, f3, a, $urandom, 1'b1);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        check("final_strobes", 32'(strobes), 32'(exp_strobes));
        for (int i = 0; i < MEMB; i++) check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 16, meaning data memory size in bytes; legal byte addresses are 0..MEM_BYTES-1.
REQ-002 SHALL have parameter CHECK_ALIGN, default 1, meaning misaligned halfword/word accesses are flagged as errors.
REQ-003 SHALL have: clk  in  1  single clock, all state on rising edge; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have: reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have: req_valid in 1 request strobe; req_ready out 1 unit idle; req_is_store in 1 store(1)/load(0); req_funct3 in 3 RV32I width/sign code; req_addr in 32 byte address; req_wdata in 32 store data.
REQ-006 SHALL have: resp_valid out 1 one-cycle completion pulse; resp_rdata out 32 extended load result; resp_err out 1 error flag, valid with resp_valid.
REQ-007 SHALL have: mem_addr out 32; mem_wdata out 32; mem_read out 1; mem_write_mode out 2 (0 none, 1 byte, 2 half, 3 word); mem_rdata in 32; all to/from the data memory, which acts on the falling clk edge.

Function
REQ-008 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-009 SHALL accept a request on a rising edge with state IDLE and req_valid=1; req_valid in any other state SHALL be ignored and not queued.
REQ-010 SHALL, on legal accept, latch address/data/funct3 and go IDLE->ACCESS; in ACCESS drive registered mem_addr=req_addr, mem_wdata=req_wdata unmodified, and exactly one of mem_read=1 (load) or mem_write_mode!=0 (store).
REQ-011 SHALL map funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; store write_mode 1/2/3 for SB/SH/SW.
REQ-012 SHALL go ACCESS->RESP on the next rising edge, capturing mem_rdata for loads; RESP lasts one cycle with resp_valid=1, then ->IDLE; legal latency: resp_valid two cycles after accept.
REQ-013 SHALL deassert mem_read and mem_write_mode (0) in every state except ACCESS.
REQ-014 SHALL extract load data with the byte at req_addr in mem_rdata[31:24]: byte = mem_rdata[31:24], half = mem_rdata[31:16], word = mem_rdata.
REQ-015 SHALL sign-extend LB/LH, zero-extend LBU/LHU; resp_rdata=0 for stores and errors.
REQ-016 SHALL flag error, with no memory strobe, when: funct3 illegal (011,110,111 loads; anything but 000-010 stores); addr+size-1 >= MEM_BYTES (compute in 33 bits, no wrap); CHECK_ALIGN=1 and half addr[0]!=0 or word addr[1:0]!=0.
REQ-017 SHALL, on error accept, go IDLE->RESP directly with resp_err=1; error latency one cycle.
REQ-018 SHALL hold resp_rdata and resp_err stable until the next accept, with meaning only while resp_valid=1.

Reset
REQ-019 SHALL, while reset_n=0, force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_read=0, mem_write_mode=0 asynchronously.
REQ-020 SHALL, on reset asserted in ACCESS, drop memory strobes immediately; a transfer cut before the falling edge SHALL not occur, and no resp_valid is ever produced for an aborted request.

Structure
REQ-021 SHALL place funct3 codes, write_mode encodings (WM_NONE/BYTE/HALF/WORD) and the FSM state encoding in shared package lsu_pkg.
REQ-022 SHALL implement extraction/extension as combinational sub-module load_align_ext (funct3, mem_rdata -> extended result).

Verification
REQ-023 SW addr 4 wdata 0x11223344, then LW addr 4 -> memory bytes 4..7 = 11,22,33,44; resp_rdata 0x11223344, resp_err 0, resp_valid two cycles after each accept.
REQ-024 SB addr 8 wdata 0x000000F0, then LB addr 8 -> 0xFFFFFFF0; LBU addr 8 -> 0x000000F0; SH addr 10 wdata 0x8001, LH addr 10 -> 0xFFFF8001, LHU -> 0x00008001.
REQ-025 LH addr 5 and LW addr 6 -> resp_err=1 after one cycle, mem_read and mem_write_mode stay 0; LW addr 12 legal; LW addr 14 and LB addr 16 -> resp_err=1 (range).
REQ-026 req_valid held high for four cycles with one LW -> exactly one accept, one resp_valid pulse, req_ready low in ACCESS/RESP.
REQ-027 SW addr 0 wdata 0xAABBCCDD, reset_n pulsed low before the falling edge of ACCESS -> memory bytes 0..3 unchanged, all outputs at reset values, no resp_valid; next LW addr 0 completes normally.
